video_osd_overlay: RTL and testbench
====================================

// Module: video_osd_overlay
// PURPOSE
//  Downstream of the LCD timing/data stage. Takes registered hs/vs/de + RGB565 pixel stream, recovers
//  pixel x/y, draws a fixed rectangular border (OSD box) over the camera image and measures the
//  active frame size per frame, flagging frames that do not match the panel geometry. Drives LCD pins.
// PARAMETERS
//  DATA_WIDTH  16       pixel width (RGB565)
//  H_ACTIVE    480      expected active pixels per line
//  V_ACTIVE    272      expected active lines per frame
//  VS_ACTIVE   1'b0     asserted level of in_vs (frame start = transition to this level)
//  BOX_X0      16       box left column;  BOX_Y0 16 box top line
//  BOX_W       128      box width (px);   BOX_H  96 box height (lines)
//  BORDER_T    2        border thickness (px/lines), 1..BOX_W/2
//  BOX_COLOR   16'hF800 border colour (red)
// PORTS
//  video_clk   in   1           pixel clock, all logic on rising edge
//  rst         in   1           synchronous, active-high reset
//  osd_en      in   1           1 = draw box; 0 = pass-through pixels
//  err_clr     in   1           one-cycle pulse clears frame_err
//  in_hs       in   1           horizontal sync from timing stage
//  in_vs       in   1           vertical sync from timing stage
//  in_de       in   1           data valid
//  in_data     in   DATA_WIDTH  pixel
//  out_hs      out  1           in_hs delayed 2 cycles
//  out_vs      out  1           in_vs delayed 2 cycles
//  out_de      out  1           in_de delayed 2 cycles
//  out_data    out  DATA_WIDTH  pixel or BOX_COLOR, 2-cycle latency
//  meas_width  out  12          de-high count of last completed line
//  meas_height out  12          line count of last completed frame
//  frame_err   out  1           sticky: geometry mismatch seen
// BEHAVIOUR
//  Reset: all outputs 0 except out_hs/out_vs = ~VS_ACTIVE... (idle sync level = ~VS_ACTIVE for both);
//   x=y=0, state IDLE. Reset mid-frame aborts measurement; no error is raised for that frame.
//  Latency: fixed 2 cycles for hs/vs/de/data, alignment preserved, no bubbles, no backpressure.
//  Stage 1: register inputs; x/y of the pixel in that stage.
//   x: 0 at first de=1 of a line, +1 per de=1 cycle, saturates at 4095.
//   de falling edge (de_r=1, de=0): meas_width<=x+1, x<=0, y<=y+1 (saturate 4095).
//   vs assert edge: y<=0; x<=0.
//  Stage 2: out_data = BOX_COLOR when osd_en & de & pixel on border, else in_data (de=0 -> 0).
//   Border: x in [BOX_X0,BOX_X0+BOX_W-1], y in [BOX_Y0,BOX_Y0+BOX_H-1], and
//   (x-BOX_X0<BORDER_T | BOX_X0+BOX_W-1-x<BORDER_T | same for y). osd_en sampled at stage 2, may
//   change anytime; takes effect on the next pixel.
//  FSM (frame measurement): IDLE -> ARMED on first vs assert edge after rst (frame in progress is
//   partial, never checked). ARMED: each line end compares x+1 to H_ACTIVE; mismatch sets line_bad.
//   Next vs assert edge: meas_height<=y; if y!=V_ACTIVE or line_bad -> frame_err<=1; line_bad<=0.
//   Frame with zero de lines: meas_height=0, error. Stays ARMED until rst.
//  frame_err: set wins over err_clr in the same cycle. meas_* hold between updates.
//  Simultaneous de fall + vs assert edge: line end processed first (width/line_bad), then the
//   frame check uses y incl. that line; y then 0.
//  Arithmetic: x,y 12-bit unsigned; compares against parameters widened to 12 bits.
// STRUCTURE
//  video_pkg: counter width (12), RGB565 colour constants, FSM state encoding (IDLE/ARMED).
//  Sub-module video_pos_counter: edge detect of de/vs, x/y counters, line/frame end strobes.
//  Top: 2-stage pipe, border compare, measurement FSM, sticky error.
// TESTING
//  1 480x272 frames, osd_en=0 -> out_data==in_data delayed 2, meas 480/272, frame_err=0.
//  2 osd_en=1, ramp pixels -> (16,16),(17,20),(143,50),(50,111) = 16'hF800; (18,18),(15,16) untouched.
//  3 one line with 479 de cycles in 2nd frame -> meas_width=479 then frame_err=1 at next vs edge;
//    err_clr pulse -> 0, stays 0 for following good frame.
//  4 frame with 271 lines -> meas_height=271, frame_err=1; err_clr same cycle as set -> remains 1.
//  5 rst asserted mid-frame for 3 cycles -> outputs 0/idle syncs, state IDLE, partial frame and
//    following first frame not checked, frame_err=0.
//  6 de fall coincident with vs assert on line 272 -> meas_height=272, no error; x saturation at 4095.

Source files
------------

// File: rtl/video_pkg.sv
// Shared definitions for the OSD overlay path: counter width, RGB565 colours, measurement states.
// Latency: none (package only).
// Backpressure: none (package only).
package video_pkg;

    localparam int CNT_W = 12;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    localparam logic [15:0] RGB565_RED   = 16'hF800;
    localparam logic [15:0] RGB565_GREEN = 16'h07E0;
    localparam logic [15:0] RGB565_BLUE  = 16'h001F;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ARMED = 1'b1
    } meas_state_e;

    // Increment that sticks at the counter ceiling instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/video_pos_counter.sv
// Recovers pixel x/y from de/vs and produces line-end / frame-start strobes.
// Latency: x/y/de_q/vs_q describe the pixel held one register stage behind the inputs.
// Backpressure: none; consumes one input beat every clock.
//
// Ports:
//   clk, rst          pixel clock, synchronous active-high reset
//   de, vs            raw data-valid and vertical sync from the timing stage
//   de_q, vs_q        de/vs registered once (stage 1)
//   x, y              column / line of the stage-1 pixel (saturating at 4095)
//   line_end          combinational: de falling (stage-1 pixel was last of its line)
//   frame_start       combinational: vs moving to its asserted level
module video_pos_counter
    import video_pkg::*;
#(
    parameter logic VS_ACTIVE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             de,
    input  logic             vs,
    output logic             de_q,
    output logic             vs_q,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             line_end,
    output logic             frame_start
);

    assign line_end    = de_q & ~de;
    assign frame_start = (vs == VS_ACTIVE) && (vs_q != VS_ACTIVE);

    always_ff @(posedge clk) begin
        if (rst) begin
            de_q <= 1'b0;
            vs_q <= ~VS_ACTIVE;
            x    <= '0;
            y    <= '0;
        end else begin
            de_q <= de;
            vs_q <= vs;
            // Frame start wins: even if a line ends on the same cycle, the
            // next frame begins at line 0 (the top consumes the old y first).
            if (frame_start) begin
                x <= '0;
                y <= '0;
            end else if (line_end) begin
                x <= '0;
                y <= sat_inc(y);
            end else if (de) begin
                x <= de_q ? sat_inc(x) : '0;
            end
        end
    end

endmodule

// File: rtl/video_osd_overlay.sv
// Draws a fixed OSD border over an RGB565 stream and checks per-frame active geometry.
// Latency: fixed 2 cycles for hs/vs/de/data, no bubbles.
// Backpressure: none; the pixel stream is never stalled.
//
// Ports:
//   video_clk, rst            pixel clock, synchronous active-high reset
//   osd_en                    draw border when 1, pass pixels through when 0
//   err_clr                   single-cycle pulse clearing frame_err (a new set wins)
//   in_hs/in_vs/in_de/in_data timing-stage sync, valid and pixel
//   out_hs/out_vs/out_de/out_data  same, delayed 2 cycles, border colour inserted
//   meas_width                de-high count of last completed line
//   meas_height               line count of last completed frame
//   frame_err                 sticky geometry-mismatch flag
module video_osd_overlay
    import video_pkg::*;
#(
    parameter int                    DATA_WIDTH = 16,
    parameter int                    H_ACTIVE   = 480,
    parameter int                    V_ACTIVE   = 272,
    parameter logic                  VS_ACTIVE  = 1'b0,
    parameter int                    BOX_X0     = 16,
    parameter int                    BOX_Y0     = 16,
    parameter int                    BOX_W      = 128,
    parameter int                    BOX_H      = 96,
    parameter int                    BORDER_T   = 2,
    parameter logic [DATA_WIDTH-1:0] BOX_COLOR  = DATA_WIDTH'(RGB565_RED)
) (
    input  logic                  video_clk,
    input  logic                  rst,
    input  logic                  osd_en,
    input  logic                  err_clr,
    input  logic                  in_hs,
    input  logic                  in_vs,
    input  logic                  in_de,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_hs,
    output logic                  out_vs,
    output logic                  out_de,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CNT_W-1:0]      meas_width,
    output logic [CNT_W-1:0]      meas_height,
    output logic                  frame_err
);

    localparam logic [CNT_W-1:0] H_EXP = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_EXP = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] BX0   = CNT_W'(BOX_X0);
    localparam logic [CNT_W-1:0] BX1   = CNT_W'(BOX_X0 + BOX_W - 1);
    localparam logic [CNT_W-1:0] BY0   = CNT_W'(BOX_Y0);
    localparam logic [CNT_W-1:0] BY1   = CNT_W'(BOX_Y0 + BOX_H - 1);
    localparam logic [CNT_W-1:0] BT    = CNT_W'(BORDER_T);

    // ---------------- stage 1 ----------------
    logic                  hs_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  de_q;
    logic                  vs_q;
    logic [CNT_W-1:0]      x;
    logic [CNT_W-1:0]      y;
    logic                  line_end;
    logic                  frame_start;

    video_pos_counter #(
        .VS_ACTIVE (VS_ACTIVE)
    ) u_pos (
        .clk         (video_clk),
        .rst         (rst),
        .de          (in_de),
        .vs          (in_vs),
        .de_q        (de_q),
        .vs_q        (vs_q),
        .x           (x),
        .y           (y),
        .line_end    (line_end),
        .frame_start (frame_start)
    );

    always_ff @(posedge video_clk) begin
        if (rst) begin
            hs_q   <= ~VS_ACTIVE;
            data_q <= '0;
        end else begin
            hs_q   <= in_hs;
            data_q <= in_data;
        end
    end

    // ---------------- border compare ----------------
    // Distances to the box edges are only meaningful once x/y are inside the
    // box, so the subtractions never need to go negative.
    logic in_box;
    logic near_edge;
    logic on_border;

    always_comb begin
        in_box    = (x >= BX0) && (x <= BX1) && (y >= BY0) && (y <= BY1);
        near_edge = ((x - BX0) < BT) || ((BX1 - x) < BT) ||
                    ((y - BY0) < BT) || ((BY1 - y) < BT);
        on_border = in_box && near_edge;
    end

    // ---------------- stage 2 ----------------
    always_ff @(posedge video_clk) begin
        if (rst) begin
            out_hs   <= ~VS_ACTIVE;
            out_vs   <= ~VS_ACTIVE;
            out_de   <= 1'b0;
            out_data <= '0;
        end else begin
            out_hs   <= hs_q;
            out_vs   <= vs_q;
            out_de   <= de_q;
            if (!de_q)
                out_data <= '0;
            else if (osd_en && on_border)
                out_data <= BOX_COLOR;
            else
                out_data <= data_q;
        end
    end

    // ---------------- frame measurement ----------------
    meas_state_e      state, state_nxt;
    logic             line_bad, line_bad_nxt;
    logic [CNT_W-1:0] height_nxt;
    logic             err_set;
    logic [CNT_W-1:0] width_now;
    logic             width_bad;
    logic [CNT_W-1:0] height_now;

    // A line ending on the same cycle as the frame edge is folded into the
    // frame it belongs to before the frame is judged.
    assign width_now  = sat_inc(x);
    assign width_bad  = line_end && (width_now != H_EXP);
    assign height_now = line_end ? sat_inc(y) : y;

    always_comb begin
        state_nxt    = state;
        line_bad_nxt = line_bad;
        height_nxt   = meas_height;
        err_set      = 1'b0;
        case (state)
            ST_IDLE: begin
                // First frame after reset is partial; start measuring from here.
                if (frame_start) begin
                    state_nxt    = ST_ARMED;
                    line_bad_nxt = 1'b0;
                end
            end
            ST_ARMED: begin
                if (width_bad)
                    line_bad_nxt = 1'b1;
                if (frame_start) begin
                    height_nxt   = height_now;
                    err_set      = (height_now != V_EXP) || line_bad || width_bad;
                    line_bad_nxt = 1'b0;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge video_clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            line_bad    <= 1'b0;
            meas_width  <= '0;
            meas_height <= '0;
            frame_err   <= 1'b0;
        end else begin
            state       <= state_nxt;
            line_bad    <= line_bad_nxt;
            meas_height <= height_nxt;
            if (line_end)
                meas_width <= width_now;
            if (err_set)
                frame_err <= 1'b1;
            else if (err_clr)
                frame_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_video_osd_overlay.sv
`timescale 1ns/1ps
module tb_video_osd_overlay;

    localparam int   H      = 144;
    localparam int   V      = 112;
    localparam logic VS_ACT = 1'b0;

    logic        video_clk = 1'b0;
    logic        rst;
    logic        osd_en;
    logic        err_clr;
    logic        in_hs;
    logic        in_vs;
    logic        in_de;
    logic [15:0] in_data;
    logic        out_hs;
    logic        out_vs;
    logic        out_de;
    logic [15:0] out_data;
    logic [11:0] meas_width;
    logic [11:0] meas_height;
    logic        frame_err;

    video_osd_overlay #(
        .H_ACTIVE (H),
        .V_ACTIVE (V)
    ) dut (
        .video_clk   (video_clk),
        .rst         (rst),
        .osd_en      (osd_en),
        .err_clr     (err_clr),
        .in_hs       (in_hs),
        .in_vs       (in_vs),
        .in_de       (in_de),
        .in_data     (in_data),
        .out_hs      (out_hs),
        .out_vs      (out_vs),
        .out_de      (out_de),
        .out_data    (out_data),
        .meas_width  (meas_width),
        .meas_height (meas_height),
        .frame_err   (frame_err)
    );

    always #5 video_clk = ~video_clk;

    int checks = 0;
    int errors = 0;

    // Beat captured by the DUT one clock ago, with its generator coordinates.
    logic        p_hs, p_vs, p_de;
    logic [15:0] p_data;
    int          p_x, p_y;
    int          osd_mode;   // 0 off, 1 on, 2 random per cycle

    // Frame-level reference model of the measurement outputs.
    int m_width, m_height, m_lines;
    bit m_err, m_armed, m_bad;

    function automatic bit on_border(input int x, input int y);
        int x1, y1;
        x1 = 16 + 128 - 1;
        y1 = 16 + 96 - 1;
        if (x < 16 || x > x1 || y < 16 || y > y1) return 1'b0;
        return (x - 16 < 2) || (x1 - x < 2) || (y - 16 < 2) || (y1 - y < 2);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic hs, input logic vs, input logic de, input int x, input int y);
        logic [15:0] d;
        logic [15:0] exp_d;
        d = 16'($urandom);
        if (osd_mode == 2) osd_en = 1'($urandom);
        else               osd_en = (osd_mode == 1);
        in_hs = hs; in_vs = vs; in_de = de; in_data = d;
        @(posedge video_clk); #1;
        if (rst) begin
            check("pipe_rst", {13'b0, out_hs, out_vs, out_de, out_data},
                  {13'b0, ~VS_ACT, ~VS_ACT, 1'b0, 16'h0000});
            p_hs = ~VS_ACT; p_vs = ~VS_ACT; p_de = 1'b0; p_data = '0; p_x = 0; p_y = 0;
        end else begin
            exp_d = p_de ? ((osd_en && on_border(p_x, p_y)) ? 16'hF800 : p_data) : 16'h0000;
            check("pipe", {13'b0, out_hs, out_vs, out_de, out_data},
                  {13'b0, p_hs, p_vs, p_de, exp_d});
            if (p_de && osd_en) begin
                if ((p_x == 16 && p_y == 16) || (p_x == 17 && p_y == 20) ||
                    (p_x == 143 && p_y == 50) || (p_x == 50 && p_y == 111))
                    check("border_px", {16'b0, out_data}, 32'h0000F800);
                if ((p_x == 18 && p_y == 18) || (p_x == 15 && p_y == 16))
                    check("plain_px", {16'b0, out_data}, {16'b0, p_data});
            end
            p_hs = hs; p_vs = vs; p_de = de; p_data = d; p_x = x; p_y = y;
        end
    endtask

    task automatic frame_event(input bit clr);
        if (m_armed) begin
            m_height = (m_lines > 4095) ? 4095 : m_lines;
            if (m_lines != V || m_bad) m_err = 1'b1;
            else if (clr)              m_err = 1'b0;
        end else begin
            m_armed = 1'b1;
            if (clr) m_err = 1'b0;
        end
        m_lines = 0;
        m_bad   = 1'b0;
    endtask

    task automatic line(input int n, input int y, input bit vs_end);
        for (int c = 0; c < n; c++) step(1'b1, 1'b1, 1'b1, c, y);
        step(1'b0, vs_end ? 1'b0 : 1'b1, 1'b0, 0, 0);
        m_width = (n > 4095) ? 4095 : n;
        m_lines++;
        if (m_armed && n != H) m_bad = 1'b1;
        check("meas_width", {20'b0, meas_width}, m_width);
        if (vs_end) begin
            frame_event(1'b0);
            check("meas_height", {20'b0, meas_height}, m_height);
            check("frame_err", {31'b0, frame_err}, {31'b0, m_err});
            step(1'b1, 1'b0, 1'b0, 0, 0);
        end
        step(1'b1, 1'b1, 1'b0, 0, 0);
    endtask

    task automatic vsync(input bit clr);
        err_clr = clr;
        step(1'b1, 1'b0, 1'b0, 0, 0);
        err_clr = 1'b0;
        frame_event(clr);
        check("meas_height", {20'b0, meas_height}, m_height);
        check("frame_err", {31'b0, frame_err}, {31'b0, m_err});
        step(1'b1, 1'b0, 1'b0, 0, 0);
        step(1'b1, 1'b1, 1'b0, 0, 0);
        step(1'b1, 1'b1, 1'b0, 0, 0);
    endtask

    task automatic frame(input int n, input int short_idx, input bit coincident);
        for (int l = 0; l < n; l++)
            line((l == short_idx) ? H - 1 : H, l, coincident && (l == n - 1));
    endtask

    task automatic clr_pulse();
        err_clr = 1'b1;
        step(1'b1, 1'b1, 1'b0, 0, 0);
        err_clr = 1'b0;
        m_err = 1'b0;
        check("err_clr", {31'b0, frame_err}, {31'b0, m_err});
    endtask

    task automatic model_reset();
        m_width = 0; m_height = 0; m_lines = 0;
        m_err = 1'b0; m_armed = 1'b0; m_bad = 1'b0;
    endtask

    task automatic check_meas(input string tag);
        check({tag, "_width"},  {20'b0, meas_width},  m_width);
        check({tag, "_height"}, {20'b0, meas_height}, m_height);
        check({tag, "_err"},    {31'b0, frame_err},   {31'b0, m_err});
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; err_clr = 1'b0; osd_en = 1'b0; osd_mode = 0;
        in_hs = 1'b1; in_vs = 1'b1; in_de = 1'b0; in_data = '0;
        p_hs = 1'b1; p_vs = 1'b1; p_de = 1'b0; p_data = '0; p_x = 0; p_y = 0;
        model_reset();

        // Reset state.
        step(1'b1, 1'b1, 1'b0, 0, 0);
        step(1'b1, 1'b1, 1'b0, 0, 0);
        check_meas("reset");
        rst = 1'b0;

        // Arm measurement, then a frame with one 143-pixel line, pass-through.
        vsync(1'b0);
        frame(V, 40, 1'b0);
        vsync(1'b0);
        clr_pulse();

        // Good frame with the box drawn; error must stay clear.
        osd_mode = 1;
        frame(V, -1, 1'b0);
        vsync(1'b0);

        // Short frame, osd_en toggling every pixel, clear colliding with set.
        osd_mode = 2;
        frame(V - 1, -1, 1'b0);
        vsync(1'b1);
        osd_mode = 0;
        clr_pulse();

        // Last line's de fall lands on the vs assert edge.
        frame(V, -1, 1'b1);

        // Over-long line saturates x; the one-line frame then errors.
        line(4100, 0, 1'b0);
        vsync(1'b0);

        // Reset in the middle of a line; partial frame after it is not judged.
        for (int l = 0; l < 5; l++) line(H, l, 1'b0);
        for (int c = 0; c < 10; c++) step(1'b1, 1'b1, 1'b1, c, 5);
        rst = 1'b1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 1'b0, 0, 0);
            check_meas("mid_rst");
        end
        rst = 1'b0;
        for (int l = 0; l < 7; l++) line(50 + l, l, 1'b0);
        vsync(1'b0);
        check_meas("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
